// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps between slots.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SCAN_CLK,
  input  logic [15:0] DIGITS,
  input  logic [3:0]  DP_EN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam logic [7:0] BCNT_LOAD = 8'(BLANK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       scan_q;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       tick;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic [6:0] seg_sel;

  assign tick   = SCAN_CLK & ~scan_q;
  assign nibble = DIGITS[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex_i (nibble),
    .seg_o (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  logic        lead_zero;

  // Digit n and every digit above it are zero exactly when DIGITS >> 4n is zero.
  assign upper     = DIGITS >> {idx_q, 2'b00};
  assign lead_zero = (idx_q != 2'd0) && (upper == 16'h0000);
  assign seg_sel   = lead_zero ? SEG_OFF : seg_dec;
`else
  assign seg_sel   = seg_dec;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    case (state_q)
      SHOW: begin
        if (tick) begin
          state_d = BLANK;
          an_d    = '1;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          bcnt_d  = BCNT_LOAD;
          idx_d   = idx_q + 2'd1;
        end
      end
      BLANK: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 8'd1;
        end else begin
          state_d = SHOW;
          an_d    = ~(4'b0001 << idx_q);
          seg_d   = seg_sel;
          dp_d    = ~DP_EN[idx_q];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= BLANK;
      idx_q   <= '0;
      bcnt_q  <= BCNT_LOAD;
      scan_q  <= 1'b1;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      scan_q  <= SCAN_CLK;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule
